// File: rtl/mac_unit_pkg.sv
// Shared types for the MAC execute unit: command encoding and FSM states.
package mac_unit_pkg;

  typedef enum logic [1:0] {
    MAC_CONTROL_MADD  = 2'b00,
    MAC_CONTROL_MSUB  = 2'b01,
    MAC_CONTROL_MMUL  = 2'b10,
    MAC_CONTROL_MLOAD = 2'b11
  } mac_control_t;

  typedef enum logic [1:0] {
    MAC_IDLE,
    MAC_MUL,
    MAC_ACC
  } mac_state_t;

  localparam int MAC_OPND_W = 32;

endpackage

// File: rtl/mac_mul_iter.sv
// Unsigned 32x32 shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
module mac_mul_iter #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] product,
  output logic        done
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  logic [63:0]      mcand;
  logic [31:0]      mplier;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      digit;

  assign digit = 64'(mplier[BITS_PER_CYCLE-1:0]);

  // High during the last iteration: product is complete after the coming edge.
  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      mcand   <= {32'b0, a_mag};
      mplier  <= b_mag;
      product <= '0;
      cnt     <= CNT_W'(N);
    end else if (cnt != '0) begin
      product <= product + mcand * digit;
      mcand   <= mcand << BITS_PER_CYCLE;
      mplier  <= mplier >> BITS_PER_CYCLE;
      cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mac_unit.sv
// MAC execute unit: signed 32x32 iterative multiply into a wide accumulator.
// Define MAC_SATURATE_EN to saturate MADD/MSUB and enable the sticky sat flag.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int ACC_W          = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  mac_control_t      cmd_op,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  mac_state_t        state;
  mac_control_t      op_q;
  logic              neg_q;
  logic [ACC_W-1:0]  acc_q;
  logic              done_q;

  logic              accept;
  logic              start_mul;
  logic              abort;
  logic              mul_done;
  logic [31:0]       a_mag;
  logic [31:0]       b_mag;
  logic [63:0]       product;
  logic [63:0]       signed_prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  load_ext;
  logic [ACC_W-1:0]  acc_next;

  assign cmd_ready = (state == MAC_IDLE) && !flush;
  assign accept    = cmd_valid && cmd_ready;
  assign start_mul = accept && (cmd_op != MAC_CONTROL_MLOAD);
  assign abort     = flush && (state != MAC_IDLE);

  // Magnitude of -2^31 is 2^31, which still fits in 32 unsigned bits.
  assign a_mag = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign b_mag = op_b[31] ? (~op_b + 32'd1) : op_b;

  mac_mul_iter #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .abort   (abort),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .product (product),
    .done    (mul_done)
  );

  assign signed_prod = neg_q ? (~product + 64'd1) : product;
  assign prod_ext    = ACC_W'($signed(signed_prod));
  assign load_ext    = ACC_W'($signed(op_a));

`ifdef MAC_SATURATE_EN
  logic             sat_q;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    sum_ext = '0;
    if (op_q == MAC_CONTROL_MSUB)
      sum_ext = {acc_q[ACC_W-1], acc_q} - {prod_ext[ACC_W-1], prod_ext};
    else
      sum_ext = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    ovf = ((op_q == MAC_CONTROL_MADD) || (op_q == MAC_CONTROL_MSUB)) &&
          (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
  end
`endif

  always_comb begin
    acc_next = acc_q;
    case (op_q)
      MAC_CONTROL_MADD: acc_next = acc_q + prod_ext;
      MAC_CONTROL_MSUB: acc_next = acc_q - prod_ext;
      MAC_CONTROL_MMUL: acc_next = prod_ext;
      default:          acc_next = acc_q;
    endcase
`ifdef MAC_SATURATE_EN
    // Clamp toward the sign of the true (ACC_W+1)-bit result.
    if (ovf)
      acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MAC_IDLE;
      op_q   <= MAC_CONTROL_MADD;
      neg_q  <= 1'b0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MAC_IDLE: begin
          if (accept) begin
            if (cmd_op == MAC_CONTROL_MLOAD) begin
              acc_q  <= load_ext;
              done_q <= 1'b1;
            end else begin
              state <= MAC_MUL;
              op_q  <= cmd_op;
              neg_q <= op_a[31] ^ op_b[31];
            end
          end
        end
        MAC_MUL: begin
          if (flush)
            state <= MAC_IDLE;
          else if (mul_done)
            state <= MAC_ACC;
        end
        MAC_ACC: begin
          state <= MAC_IDLE;
          if (!flush) begin
            acc_q  <= acc_next;
            done_q <= 1'b1;
          end
        end
        default: state <= MAC_IDLE;
      endcase
    end
  end

`ifdef MAC_SATURATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (accept && (cmd_op == MAC_CONTROL_MLOAD)) begin
      sat_q <= 1'b0;
    end else if ((state == MAC_ACC) && !flush) begin
      if (op_q == MAC_CONTROL_MMUL)
        sat_q <= 1'b0;
      else if (ovf)
        sat_q <= 1'b1;
    end
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign acc_out = acc_q;
  assign busy    = (state != MAC_IDLE);
  assign done    = done_q;

endmodule
